// File: rtl/smc_counter_lite.sv
`default_nettype none
// ============================================================================
//  Module   : smc_counter_lite
//  Purpose  : Per-access timing counters (CSLE / WS / CSTE) and timing stores
//             feeding the lite SMC state machine.
//  Revision : 1.0  initial release
// ============================================================================
module smc_counter_lite #(
   parameter int WS_W   = 8,
   parameter int EDGE_W = 2
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic              valid_access,
   input  logic              le_enable,
   input  logic              ws_enable,
   input  logic              cste_enable,
   input  logic              smc_done,
   input  logic              mac_done,
   input  logic [EDGE_W-1:0] cfg_csle,
   input  logic [WS_W-1:0]   cfg_ws,
   input  logic [EDGE_W-1:0] cfg_cste,
   input  logic [EDGE_W-1:0] cfg_oete,
   output logic [EDGE_W-1:0] r_csle_count,
   output logic [WS_W-1:0]   r_ws_count,
   output logic [EDGE_W-1:0] r_cste_count,
   output logic [EDGE_W-1:0] r_csle_store,
   output logic [EDGE_W-1:0] r_oete_store,
   output logic [WS_W-1:0]   r_ws_store,
   output logic [EDGE_W-1:0] r_cste_store,
   output logic              counts_zero
);

   localparam logic [EDGE_W-1:0] c_EDGE_ONE = EDGE_W'(1);
   localparam logic [WS_W-1:0]   c_WS_ONE   = WS_W'(1);

   // Next beat of a multiple access: replay the timings captured at its start.
   logic w_reload;
   assign w_reload = smc_done & ~mac_done & ~valid_access;

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         r_csle_store <= '0;
         r_oete_store <= '0;
         r_ws_store   <= '0;
         r_cste_store <= '0;
      end else if (valid_access) begin
         r_csle_store <= cfg_csle;
         r_oete_store <= cfg_oete;
         r_ws_store   <= cfg_ws;
         r_cste_store <= cfg_cste;
      end
   end

   // Decrements saturate at zero; load beats reload beats decrement.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         r_csle_count <= '0;
         r_ws_count   <= '0;
         r_cste_count <= '0;
      end else if (valid_access) begin
         r_csle_count <= cfg_csle;
         r_ws_count   <= cfg_ws;
         r_cste_count <= cfg_cste;
      end else if (w_reload) begin
         r_csle_count <= r_csle_store;
         r_ws_count   <= r_ws_store;
         r_cste_count <= r_cste_store;
      end else begin
         if (le_enable && (r_csle_count != '0))
            r_csle_count <= r_csle_count - c_EDGE_ONE;
         if (ws_enable && (r_ws_count != '0))
            r_ws_count <= r_ws_count - c_WS_ONE;
         if (cste_enable && (r_cste_count != '0))
            r_cste_count <= r_cste_count - c_EDGE_ONE;
      end
   end

   assign counts_zero = (r_csle_count == '0) && (r_ws_count == '0) &&
                        (r_cste_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_smc_counter_lite.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smc_counter_lite
//  Purpose  : Directed self-checking bench for smc_counter_lite.
//  Revision : 1.0  initial release
// ============================================================================
module tb_smc_counter_lite;

   logic       sys_clk = 1'b0;
   logic       sys_reset;
   logic       valid_access, le_enable, ws_enable, cste_enable;
   logic       smc_done, mac_done;
   logic [1:0] cfg_csle, cfg_cste, cfg_oete;
   logic [7:0] cfg_ws;
   logic [1:0] r_csle_count, r_cste_count, r_csle_store, r_oete_store, r_cste_store;
   logic [7:0] r_ws_count, r_ws_store;
   logic       counts_zero;

   int errors = 0;
   int checks = 0;

   always #5 sys_clk = ~sys_clk;

   smc_counter_lite #(.WS_W(8), .EDGE_W(2)) dut (
      .sys_clk      (sys_clk),
      .sys_reset    (sys_reset),
      .valid_access (valid_access),
      .le_enable    (le_enable),
      .ws_enable    (ws_enable),
      .cste_enable  (cste_enable),
      .smc_done     (smc_done),
      .mac_done     (mac_done),
      .cfg_csle     (cfg_csle),
      .cfg_ws       (cfg_ws),
      .cfg_cste     (cfg_cste),
      .cfg_oete     (cfg_oete),
      .r_csle_count (r_csle_count),
      .r_ws_count   (r_ws_count),
      .r_cste_count (r_cste_count),
      .r_csle_store (r_csle_store),
      .r_oete_store (r_oete_store),
      .r_ws_store   (r_ws_store),
      .r_cste_store (r_cste_store),
      .counts_zero  (counts_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected counts csle/ws/cste, stores csle/oete/ws/cste, counts_zero.
   task automatic chk_all(input string tag, input int c, input int w, input int t,
                          input int sc, input int so, input int sw, input int st,
                          input int z);
      chk({tag, ".csle_cnt"}, 32'(r_csle_count), c);
      chk({tag, ".ws_cnt"},   32'(r_ws_count),   w);
      chk({tag, ".cste_cnt"}, 32'(r_cste_count), t);
      chk({tag, ".csle_st"},  32'(r_csle_store), sc);
      chk({tag, ".oete_st"},  32'(r_oete_store), so);
      chk({tag, ".ws_st"},    32'(r_ws_store),   sw);
      chk({tag, ".cste_st"},  32'(r_cste_store), st);
      chk({tag, ".zero"},     32'(counts_zero),  z);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      sys_reset = 1'b1;
      valid_access = 0; le_enable = 0; ws_enable = 0; cste_enable = 0;
      smc_done = 0; mac_done = 0;
      cfg_csle = 0; cfg_ws = 0; cfg_cste = 0; cfg_oete = 0;
      tick(); tick();
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 1);
      sys_reset = 1'b0;
      tick();
      chk_all("post_release", 0, 0, 0, 0, 0, 0, 0, 1);

      // Single access
      cfg_csle = 2; cfg_ws = 3; cfg_cste = 1; cfg_oete = 1; valid_access = 1;
      tick();
      valid_access = 0;
      chk_all("load", 2, 3, 1, 2, 1, 3, 1, 0);
      le_enable = 1;
      tick(); chk("le1.csle", 32'(r_csle_count), 1);
      tick(); chk("le2.csle", 32'(r_csle_count), 0);
      le_enable = 0;
      ws_enable = 1;
      tick(); chk("ws1", 32'(r_ws_count), 2);
      tick(); chk("ws2", 32'(r_ws_count), 1);
      tick(); chk("ws3", 32'(r_ws_count), 0);
      for (int i = 0; i < 4; i++) begin
         tick(); chk("ws_sat", 32'(r_ws_count), 0);
      end
      ws_enable = 0;
      cste_enable = 1;
      tick();
      cste_enable = 0;
      chk_all("cste_done", 0, 0, 0, 2, 1, 3, 1, 1);

      // cfg change without load is ignored
      cfg_csle = 3; cfg_ws = 9; cfg_cste = 3; cfg_oete = 3;
      tick();
      chk_all("cfg_ignored", 0, 0, 0, 2, 1, 3, 1, 1);

      // Multiple-access reload
      cfg_csle = 1; cfg_ws = 2; cfg_cste = 1; cfg_oete = 2; valid_access = 1;
      tick();
      valid_access = 0;
      chk_all("mload", 1, 2, 1, 1, 2, 2, 1, 0);
      le_enable = 1; ws_enable = 1; cste_enable = 1;
      tick(); tick();
      le_enable = 0; cste_enable = 0;
      chk_all("drained", 0, 0, 0, 1, 2, 2, 1, 1);
      smc_done = 1; mac_done = 0;   // ws_enable still high: reload must win
      tick();
      chk_all("reload", 1, 2, 1, 1, 2, 2, 1, 0);
      ws_enable = 0; mac_done = 1;
      tick();
      chk_all("mac_done_hold", 1, 2, 1, 1, 2, 2, 1, 0);

      // Load beats reload and decrement
      cfg_csle = 3; cfg_ws = 7; cfg_cste = 3; cfg_oete = 0;
      valid_access = 1; smc_done = 1; mac_done = 0; ws_enable = 1;
      tick();
      valid_access = 0; smc_done = 0; ws_enable = 0;
      chk_all("prio_load", 3, 7, 3, 3, 0, 7, 3, 0);

      // Counting continues through cfg changes
      cfg_ws = 3; valid_access = 1;
      tick();
      valid_access = 0;
      chk("iso_load", 32'(r_ws_count), 3);
      cfg_ws = 9; ws_enable = 1;
      tick(); chk("iso1", 32'(r_ws_count), 2); chk("iso1.st", 32'(r_ws_store), 3);
      tick(); chk("iso2", 32'(r_ws_count), 1); chk("iso2.st", 32'(r_ws_store), 3);
      tick(); chk("iso3", 32'(r_ws_count), 0); chk("iso3.st", 32'(r_ws_store), 3);
      ws_enable = 0;

      // Asynchronous reset mid-count
      cfg_csle = 2; cfg_ws = 5; cfg_cste = 2; cfg_oete = 1; valid_access = 1;
      tick();
      valid_access = 0;
      chk("pre_arst.ws", 32'(r_ws_count), 5);
      #2 sys_reset = 1'b1;
      #1 chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      sys_reset = 1'b0;
      le_enable = 1; ws_enable = 1; cste_enable = 1; smc_done = 1; mac_done = 0;
      tick(); tick();
      le_enable = 0; ws_enable = 0; cste_enable = 0; smc_done = 0;
      chk_all("after_reset", 0, 0, 0, 0, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
